// File: rtl/boid_pkg.sv
// Shared types and framebuffer geometry for the boid pixel pipeline.
// The renderer state set depends on BOID_RENDERER_ERASE_EN.
package boid_pkg;

  typedef logic signed [31:0] fix16_t;
  typedef logic [7:0]         color_t;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_ADDR_W = 19;

`ifdef BOID_RENDERER_ERASE_EN
  typedef enum logic [1:0] {IDLE, ERASE, DRAW} render_state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAW} render_state_t;
`endif

endpackage

// File: rtl/pix_addr_gen.sv
// Combinational clip test and linear framebuffer address for one pixel.
module pix_addr_gen
  import boid_pkg::*;
#(
  parameter int H_RES = boid_pkg::H_RES,
  parameter int V_RES = boid_pkg::V_RES
) (
  input  logic signed [16:0]          cx,
  input  logic signed [16:0]          cy,
  output logic                        in_bounds,
  output logic [FB_ADDR_W-1:0]        wr_addr
);

  localparam logic signed [16:0] H_LIM = 17'(H_RES);
  localparam logic signed [16:0] V_LIM = 17'(V_RES);

  always_comb begin
    in_bounds = !cx[16] && (cx < H_LIM) && !cy[16] && (cy < V_LIM);
    // cy*640 as two shifts; upper coordinate bits only matter when clipped
    wr_addr   = {cy[9:0], 9'b0} + {2'b0, cy[9:0], 7'b0} + {9'b0, cx[9:0]};
  end

endmodule

// File: rtl/boid_renderer.sv
// Streams a SIZE x SIZE boid sprite as single-pixel framebuffer writes.
// Define BOID_RENDERER_ERASE_EN to erase the previous sprite before drawing.
module boid_renderer
  import boid_pkg::*;
#(
  parameter int         SIZE       = 2,
  parameter logic [7:0] BOID_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR   = 8'h00,
  parameter int         H_RES      = boid_pkg::H_RES,
  parameter int         V_RES      = boid_pkg::V_RES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] px,
  input  logic [31:0] py,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);

  localparam int             CW   = 4;
  localparam logic [CW-1:0]  LAST = CW'(SIZE - 1);

`ifdef BOID_RENDERER_ERASE_EN
  localparam render_state_t FIRST_PHASE = ERASE;
`else
  localparam render_state_t FIRST_PHASE = DRAW;
`endif

  render_state_t state_reg, state_next;
  logic [CW-1:0] dx_reg, dx_next, dy_reg, dy_next;
  logic          done_reg, done_next;
  logic          accept;
  logic signed [15:0] x_reg, y_reg;
  logic signed [15:0] base_x, base_y;
  logic signed [16:0] cx, cy;
  logic          in_bounds, advance;
  logic [FB_ADDR_W-1:0] pix_addr;

`ifdef BOID_RENDERER_ERASE_EN
  logic signed [15:0] px_reg, py_reg;
  logic unused_bits;
  assign unused_bits = ^{x[15:0], y[15:0], px[15:0], py[15:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      px_reg <= '0;
      py_reg <= '0;
    end else if (accept) begin
      px_reg <= px[31:16];
      py_reg <= py[31:16];
    end
  end

  assign base_x = (state_reg == ERASE) ? px_reg : x_reg;
  assign base_y = (state_reg == ERASE) ? py_reg : y_reg;
`else
  // Trail mode: previous positions are never consulted.
  logic unused_bits;
  assign unused_bits = ^{x[15:0], y[15:0], px, py};
  assign base_x = x_reg;
  assign base_y = y_reg;
`endif

  assign cx = {base_x[15], base_x} + {{(17 - CW){1'b0}}, dx_reg};
  assign cy = {base_y[15], base_y} + {{(17 - CW){1'b0}}, dy_reg};

  pix_addr_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_addr (
    .cx        (cx),
    .cy        (cy),
    .in_bounds (in_bounds),
    .wr_addr   (pix_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      dx_reg    <= '0;
      dy_reg    <= '0;
      done_reg  <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      dx_reg    <= dx_next;
      dy_reg    <= dy_next;
      done_reg  <= done_next;
      if (accept) begin
        x_reg <= x[31:16];
        y_reg <= y[31:16];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    dx_next    = dx_reg;
    dy_next    = dy_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    // Clipped slots never wait on the memory side.
    advance    = in_bounds ? wr_ready : 1'b1;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          dx_next    = '0;
          dy_next    = '0;
          state_next = FIRST_PHASE;
        end
      end
      default: begin
        if (advance) begin
          if (dx_reg == LAST) begin
            dx_next = '0;
            if (dy_reg == LAST) begin
              dy_next = '0;
              if (state_reg == DRAW) begin
                state_next = IDLE;
                done_next  = 1'b1;
              end else begin
                state_next = DRAW;
              end
            end else begin
              dy_next = dy_reg + 1'b1;
            end
          end else begin
            dx_next = dx_reg + 1'b1;
          end
        end
      end
    endcase
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = !in_ready;
  assign done     = done_reg;
  assign wr_en    = busy && in_bounds;
  assign wr_addr  = wr_en ? pix_addr : '0;
  assign wr_data  = (state_reg == DRAW) ? BOID_COLOR :
                    (state_reg == IDLE) ? 8'h00 : BG_COLOR;

endmodule

// File: tb/tb_boid_renderer.sv
// Self-checking bench for boid_renderer: job table plus reset-abort sequence,
// with a write scoreboard built from an independent pixel model.
module tb_boid_renderer;
  import boid_pkg::*;

  localparam int SIZE = 2;
`ifdef BOID_RENDERER_ERASE_EN
  localparam int PHASES = 2;
`else
  localparam int PHASES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  fix16_t      x = '0, y = '0, px = '0, py = '0;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  boid_renderer #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .px       (px),
    .py       (py),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    string  name;
    fix16_t x, y, px, py;
    int     stall;
    int     wr_erase;
    int     wr_trail;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   errors = 0;
  int   checks = 0;
  int   wr_count = 0;
  vec_t vecs[7];

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Write monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && wr_en && wr_ready) begin
      wr_count++;
      $display("write addr=%0d data=%02h", wr_addr, wr_data);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {13'b0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {13'b0, wr_addr}, {13'b0, mon_e.addr});
        check("wr_data", {24'b0, wr_data}, {24'b0, mon_e.data});
      end
    end
  end

  function automatic void push_job(fix16_t jx, fix16_t jy, fix16_t jpx, fix16_t jpy);
    wr_t w;
    for (int ph = 0; ph < PHASES; ph++) begin
      bit erase = (PHASES == 2) && (ph == 0);
      int bx = erase ? int'(jpx >>> 16) : int'(jx >>> 16);
      int by = erase ? int'(jpy >>> 16) : int'(jy >>> 16);
      for (int dy = 0; dy < SIZE; dy++) begin
        for (int dx = 0; dx < SIZE; dx++) begin
          int cx = bx + dx;
          int cy = by + dy;
          if (cx >= 0 && cx < 640 && cy >= 0 && cy < 480) begin
            w.addr = 19'(cy * 640 + cx);
            w.data = erase ? 8'h00 : 8'hFF;
            exp_q.push_back(w);
          end
        end
      end
    end
  endfunction

  // Caller is positioned 1 time unit after a rising edge; that cycle is cycle 0.
  task automatic run_job(string name, fix16_t jx, fix16_t jy, fix16_t jpx, fix16_t jpy,
                         int stall, int exp_writes);
    int cyc;
    int got;
    int exp_done;
    exp_done = PHASES * SIZE * SIZE + 1 + stall;
    push_job(jx, jy, jpx, jpy);
    wr_count = 0;
    x = jx; y = jy; px = jpx; py = jpy;
    in_valid = 1'b1;
    wr_ready = (stall > 0) ? 1'b0 : 1'b1;
    @(negedge clk);
    check({name, "_in_ready_c0"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after handshake; the job must not see them.
    x = 32'h0123_4567; y = 32'h0089_ABCD; px = 32'h0042_0000; py = 32'h0017_0000;
    cyc = 1;
    got = 0;
    wr_ready = (cyc <= stall) ? 1'b0 : 1'b1;
    while (cyc < 40) begin
      @(negedge clk);
      if (done) begin
        got = cyc;
        break;
      end
      check({name, "_busy"}, {31'b0, busy}, 32'd1);
      if (cyc <= stall && exp_q.size() > 0) begin
        check({name, "_stall_wr_en"}, {31'b0, wr_en}, 32'd1);
        check({name, "_stall_addr"}, {13'b0, wr_addr}, {13'b0, exp_q[0].addr});
        check({name, "_stall_data"}, {24'b0, wr_data}, {24'b0, exp_q[0].data});
      end
      @(posedge clk); #1;
      cyc++;
      wr_ready = (cyc <= stall) ? 1'b0 : 1'b1;
    end
    $display("job %s done_cycle=%0d writes=%0d", name, got, wr_count);
    check({name, "_done_cycle"}, got, exp_done);
    check({name, "_in_ready_done"}, {31'b0, in_ready}, 32'd1);
    check({name, "_busy_done"}, {31'b0, busy}, 32'd0);
    check({name, "_writes"}, wr_count, exp_writes);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    exp_q.delete();
    wr_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{"basic",   32'd100 << 16, 32'd50 << 16,  32'd98 << 16,  32'd50 << 16,  0, 8, 4};
    vecs[1] = '{"clip",    32'd639 << 16, 32'd479 << 16, 32'd0,         32'd0,         0, 5, 1};
    vecs[2] = '{"neg_x",   32'hFFFF_0000, 32'd0,         32'd0,         32'd0,         0, 6, 2};
    vecs[3] = '{"frac",    32'h0064_FFFF, 32'h0032_7FFF, 32'h0062_8000, 32'd50 << 16,  0, 8, 4};
    vecs[4] = '{"stall",   32'd100 << 16, 32'd50 << 16,  32'd98 << 16,  32'd50 << 16,  3, 8, 4};
    vecs[5] = '{"offscr",  32'd1000 << 16, 32'hFFFB_0000, 32'hFF9C_0000, 32'hFF9C_0000, 0, 0, 0};
    vecs[6] = '{"corner",  32'd0,         32'd478 << 16, 32'd639 << 16, 32'd479 << 16, 0, 5, 4};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_done",     {31'b0, done},     32'd0);
    check("rst_wr_en",    {31'b0, wr_en},    32'd0);
    check("rst_wr_addr",  {13'b0, wr_addr},  32'd0);
    check("rst_wr_data",  {24'b0, wr_data},  32'd0);

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].px, vecs[i].py, vecs[i].stall,
              (PHASES == 2) ? vecs[i].wr_erase : vecs[i].wr_trail);
    end

    // Abort a job with reset asserted during cycle 3.
    push_job(32'd100 << 16, 32'd50 << 16, 32'd98 << 16, 32'd50 << 16);
    x = 32'd100 << 16; y = 32'd50 << 16; px = 32'd98 << 16; py = 32'd50 << 16;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    $display("job abort reset applied");
    check("abort_wr_en",    {31'b0, wr_en},    32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_busy",     {31'b0, busy},     32'd0);
    check("abort_done",     {31'b0, done},     32'd0);
    run_job("after_abort", 32'd100 << 16, 32'd50 << 16, 32'd98 << 16, 32'd50 << 16, 0,
            (PHASES == 2) ? 8 : 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boid_renderer.md
# boid_renderer

Per-boid pixel writer that sits directly downstream of the boid update datapath. It accepts one boid's current and previous positions in 16.16 fixed point. It optionally erases the SIZE×SIZE sprite at the previous position, then draws the sprite at the current position, as a stream of single-pixel writes into the 640×480 8-bit VGA framebuffer held in M10k. Writes are flow-controlled by the memory side; off-screen pixels are clipped.

## Interface
- SIZE, 2, sprite edge length in pixels (1..8)
- BOID_COLOR, 8'hFF, colour written in draw phase
- BG_COLOR, 8'h00, colour written in erase phase
- H_RES, 640, framebuffer width
- V_RES, 480, framebuffer height
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  boid job offered
- in_ready  out  1  block idle, accepting a job
- x, y  in  32  current position, 16.16 signed
- px, py  in  32  previous position, 16.16 signed
- wr_en  out  1  pixel write valid
- wr_ready  in  1  memory accepts write this cycle
- wr_addr  out  19  linear address, y*H_RES + x
- wr_data  out  8  pixel colour
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job finished

## Operation
- FSM states: IDLE, ERASE, DRAW.
- IDLE: in_ready=1. On in_valid && in_ready, latch integer parts (bits [31:16], signed 16-bit) of x, y, px, py and clear counters dx=dy=0. Go to ERASE, or to DRAW when erase is compiled out.
- Pixel slot: coordinate = latched base + {dx, dy}, computed as signed 17-bit. In-bounds iff 0 ≤ cx < H_RES and 0 ≤ cy < V_RES.
  - In-bounds slot: wr_en=1, wr_addr = cy*H_RES + cx (computed as (cy<<9)+(cy<<7)+cx), wr_data = BG_COLOR in ERASE, BOID_COLOR in DRAW. The slot advances only on wr_en && wr_ready.
  - Out-of-bounds slot: wr_en=0. The slot advances unconditionally in one cycle.
- Slot order is row-major: dx runs 0..SIZE-1, then dy increments.
- After the last slot of ERASE, go to DRAW with counters cleared. After the last slot of DRAW, go to IDLE and pulse done.
- Fractional bits of all positions are ignored (truncation toward −∞).
- wr_en, wr_addr and wr_data are combinational from registered state only. They never depend on wr_ready.
- reset at any time: next cycle state=IDLE, wr_en=0, done=0, busy=0, in_ready=1, counters=0. An interrupted job is abandoned and produces no done.

## Timing
- Reset values: in_ready=1, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0.
- Handshake in cycle 0. First slot is presented in cycle 1.
- With no stalls, each slot takes one cycle. The job takes 2·SIZE² slot cycles (SIZE² without erase).
- done and in_ready rise in the cycle after the final slot. A new job may be accepted in that same cycle.
- While wr_en=1 && wr_ready=0, wr_addr, wr_data and wr_en hold stable.
- busy=1 from cycle 1 through the final slot cycle.
- Inputs x/y/px/py are sampled only at handshake; later changes are ignored.

## Configuration
- BOID_RENDERER_ERASE_EN defined: the ERASE phase runs before DRAW.
- Not defined: the ERASE state is absent, IDLE goes straight to DRAW, and previous positions are unused (trail mode). Each job produces SIZE² slots.

## Structure
- Shared package boid_pkg holds:
  - typedef fix16_t (logic signed [31:0])
  - typedef color_t (logic [7:0])
  - H_RES, V_RES, and FB_ADDR_W=19
  - renderer state enum
- One sub-module, pix_addr_gen: combinational; takes signed cx, cy; outputs in_bounds and wr_addr.

## Test plan
1. SIZE=2, erase on, x=100<<16, y=50<<16, px=98<<16, py=50<<16, wr_ready=1 → writes 32098, 32099, 32738, 32739 with data 00, then 32100, 32101, 32740, 32741 with data FF, in cycles 1–8. done=1 and in_ready=1 in cycle 9.
2. Clipping: x=639<<16, y=479<<16, px=py=0 → draw phase writes only addr 307199 with data FF. The three clipped slots each take one cycle with wr_en=0; done still arrives in cycle 9.
3. Negative coordinate: x=32'hFFFF0000 (−1), y=0 → draw writes only addr 0 and addr 640. x=32'h0064FFFF behaves as x=100.
4. Backpressure: wr_ready=0 for cycles 1–3 → wr_en/addr/data held at the first slot values; all later writes shift by 3; done arrives in cycle 12.
5. Reset in cycle 3 of a job → cycle 4: wr_en=0, in_ready=1, busy=0; done never pulses. A new job issued in cycle 4 completes normally.
6. BOID_RENDERER_ERASE_EN undefined, test 1 stimulus → only the four FF writes occur, in cycles 1–4; done in cycle 5.
